// File: rtl/product_bcd_conv_pkg.sv
// Shared definitions for the signed-product-to-BCD converter: default sizes,
// FSM state encoding and the BCD digit type.
package product_bcd_conv_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_N_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/product_bcd_conv_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import product_bcd_conv_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t corrected
);

  assign corrected = (digit >= 4'd5) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential signed-binary to packed-BCD converter (shift-add-3, one bit per clock).
// Optional macro BCD_LEADING_ZERO_BLANK_EN enables leading-zero blanking on `blank`.
module product_bcd_conv
  import product_bcd_conv_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int N_DIGITS = DEFAULT_N_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     product,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic [N_DIGITS-1:0]   blank
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state_reg;
  logic [DATA_W:0]    mag_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_lat_reg;

  logic [DATA_W:0]    prod_ext;
  logic [DATA_W:0]    abs_full;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_next;
  logic [N_DIGITS-1:0] blank_next;

  // Magnitude is formed one bit wider so the most negative product is exact.
  assign prod_ext = {product[DATA_W-1], product};
  assign abs_full = product[DATA_W-1] ? (~prod_ext + 1'b1) : prod_ext;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .digit     (scratch_reg[4*gi +: 4]),
        .corrected (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign scratch_next = {scratch_adj[BCD_W-2:0], mag_reg[DATA_W-1]};

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; everything above the first non-zero digit is blanked.
  always_comb begin
    logic seen;
    blank_next = '0;
    seen       = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (scratch_next[4*i +: 4] != 4'd0) seen = 1'b1;
      blank_next[i] = ~seen;
    end
  end
`else
  assign blank_next = '0;
`endif

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mag_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      sign_lat_reg <= 1'b0;
      done         <= 1'b0;
      sign         <= 1'b0;
      bcd          <= '0;
      blank        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            mag_reg      <= abs_full;
            sign_lat_reg <= product[DATA_W-1];
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          scratch_reg <= scratch_next;
          mag_reg     <= mag_reg << 1;
          cnt_reg     <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            bcd       <= scratch_next;
            sign      <= sign_lat_reg;
            blank     <= blank_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed self-checking bench for product_bcd_conv; honours BCD_LEADING_ZERO_BLANK_EN
// when choosing the expected blanking masks.
module tb_product_bcd_conv;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        sign;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int errors;
  int checks;

  product_bcd_conv dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .product  (product),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .bcd      (bcd),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exp_blank(input logic [4:0] with_macro);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return with_macro;
`else
    return 5'b00000;
`endif
  endfunction

  // Pulses valid_in from the current negedge, then counts negedges until done.
  task automatic run_conv(input logic [15:0] p, output int lat, output logic timed_out,
                          output logic busy_after);
    valid_in = 1'b1;
    product  = p;
    @(negedge clk);
    valid_in   = 1'b0;
    busy_after = busy;
    lat        = 0;
    timed_out  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat       = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; product = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    if (sign !== 1'b0)   begin errors++; $display("FAIL reset_sign got=%b want=0", sign); end
    if (bcd !== 20'h0)   begin errors++; $display("FAIL reset_bcd got=%h want=00000", bcd); end
    if (blank !== 5'b0)  begin errors++; $display("FAIL reset_blank got=%b want=00000", blank); end
    $display("reset: busy=%b done=%b sign=%b bcd=%h blank=%b", busy, done, sign, bcd, blank);
  endtask

  task automatic test_value(input string name, input logic [15:0] p, input logic exp_sign,
                            input logic [19:0] exp_bcd, input logic [4:0] blank_macro);
    int lat; logic to; logic b;
    @(negedge clk);
    run_conv(p, lat, to, b);
    checks += 6;
    if (to !== 1'b0)   begin errors++; $display("FAIL %s_timeout got=%b want=0", name, to); end
    if (b !== 1'b1)    begin errors++; $display("FAIL %s_busy got=%b want=1", name, b); end
    if (lat != 17)     begin errors++; $display("FAIL %s_latency got=%0d want=17", name, lat); end
    if (sign !== exp_sign) begin errors++; $display("FAIL %s_sign got=%b want=%b", name, sign, exp_sign); end
    if (bcd !== exp_bcd)   begin errors++; $display("FAIL %s_bcd got=%h want=%h", name, bcd, exp_bcd); end
    if (blank !== exp_blank(blank_macro))
      begin errors++; $display("FAIL %s_blank got=%b want=%b", name, blank, exp_blank(blank_macro)); end
    $display("%s: product=%h lat=%0d sign=%b bcd=%h blank=%b", name, p, lat, sign, bcd, blank);
  endtask

  task automatic test_ignore();
    int lat; logic to;
    @(negedge clk);
    valid_in = 1'b1; product = 16'd42;
    @(negedge clk);
    valid_in = 1'b0;
    lat = 0; to = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3)  begin valid_in = 1'b1; product = 16'd99; end
      if (i == 11) valid_in = 1'b0;
      @(negedge clk);
      if (done) begin lat = i; to = 1'b0; break; end
    end
    checks += 3;
    if (to !== 1'b0)     begin errors++; $display("FAIL ignore_timeout got=%b want=0", to); end
    if (lat != 17)       begin errors++; $display("FAIL ignore_latency got=%0d want=17", lat); end
    if (bcd !== 20'h00042) begin errors++; $display("FAIL ignore_bcd got=%h want=00042", bcd); end
    repeat (5) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got=%b want=0", busy); end
    if (bcd !== 20'h00042) begin errors++; $display("FAIL ignore_hold_bcd got=%h want=00042", bcd); end
    $display("ignore: lat=%0d bcd=%h busy=%b", lat, bcd, busy);
    test_value("after_ignore_99", 16'd99, 1'b0, 20'h00099, 5'b11100);
  endtask

  task automatic test_back_to_back();
    int lat; logic to; logic b;
    @(negedge clk);
    run_conv(16'd1234, lat, to, b);
    checks += 2;
    if (to !== 1'b0 || lat != 17) begin errors++; $display("FAIL b2b_first_latency got=%0d want=17", lat); end
    if (bcd !== 20'h01234) begin errors++; $display("FAIL b2b_first_bcd got=%h want=01234", bcd); end
    // Present the next product in the cycle right after done.
    run_conv(16'd9999, lat, to, b);
    checks += 4;
    if (b !== 1'b1)      begin errors++; $display("FAIL b2b_accept got=%b want=1", b); end
    if (to !== 1'b0 || lat != 17) begin errors++; $display("FAIL b2b_second_latency got=%0d want=17", lat); end
    if (bcd !== 20'h09999) begin errors++; $display("FAIL b2b_second_bcd got=%h want=09999", bcd); end
    if (blank !== exp_blank(5'b10000))
      begin errors++; $display("FAIL b2b_second_blank got=%b want=%b", blank, exp_blank(5'b10000)); end
    $display("back_to_back: lat=%0d bcd=%h blank=%b", lat, bcd, blank);
  endtask

  task automatic test_rst_mid();
    int dones;
    @(negedge clk);
    valid_in = 1'b1; product = -16'sd100;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    if (done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b want=0", done); end
    if (sign !== 1'b0)  begin errors++; $display("FAIL rstmid_sign got=%b want=0", sign); end
    if (bcd !== 20'h0)  begin errors++; $display("FAIL rstmid_bcd got=%h want=00000", bcd); end
    if (blank !== 5'b0) begin errors++; $display("FAIL rstmid_blank got=%b want=00000", blank); end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks += 1;
    if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
    $display("rst_mid: busy=%b bcd=%h sign=%b dones=%0d", busy, bcd, sign, dones);
    test_value("after_rst_7", 16'd7, 1'b0, 20'h00007, 5'b11110);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_value("pos_15",     16'd15,     1'b0, 20'h00015, 5'b11100);
    test_value("neg_16256",  16'hC080,   1'b1, 20'h16256, 5'b00000);
    test_value("min_32768",  16'h8000,   1'b1, 20'h32768, 5'b00000);
    test_value("zero",       16'h0000,   1'b0, 20'h00000, 5'b11110);
    test_value("max_32767",  16'h7FFF,   1'b0, 20'h32767, 5'b00000);
    test_value("neg_1",      16'hFFFF,   1'b1, 20'h00001, 5'b11110);
    test_ignore();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
